serial_comp_ctrl: RTL and testbench

//  Sequencer that shares one 2-bit magnitude comparator slice (x,y -> xly,xgy,xey)

---
 rtl/serial_comp_ctrl.sv | 119 +++++++++++
 tb/tb_serial_comp_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_comp_ctrl.sv
// Sequencer sharing one external 2-bit comparator slice across a WIDTH-bit operand pair.
// Digits are scanned MSB-first; the scan stops at the first unequal digit.
module serial_comp_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             gt,
   output logic             eq,
   output logic             err,
   output logic [1:0]       cmp_x,
   output logic [1:0]       cmp_y,
   input  logic             cmp_xly,
   input  logic             cmp_xgy,
   input  logic             cmp_xey
);

   localparam int unsigned NDIG = WIDTH / 2;
   localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e          state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             onehot;

   assign a_sh = a_q >> {idx_q, 1'b0};
   assign b_sh = b_q >> {idx_q, 1'b0};

   // The slice is only driven while scanning; otherwise it sees zeros.
   always_comb begin
      cmp_x = 2'b00;
      cmp_y = 2'b00;
      if (state_q == StScan) begin
         cmp_x = a_sh[1:0];
         cmp_y = b_sh[1:0];
      end
   end

   always_comb begin
      onehot = 1'b0;
      case ({cmp_xly, cmp_xgy, cmp_xey})
         3'b100, 3'b010, 3'b001: onehot = 1'b1;
         default:                onehot = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         lt      <= 1'b0;
         gt      <= 1'b0;
         eq      <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               done <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  idx_q   <= IW'(NDIG - 1);
                  lt      <= 1'b0;
                  gt      <= 1'b0;
                  eq      <= 1'b0;
                  err     <= 1'b0;
                  busy    <= 1'b1;
                  state_q <= StScan;
               end
            end
            StScan: begin
               if (!onehot) begin
                  err     <= 1'b1;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else if (cmp_xgy) begin
                  gt      <= 1'b1;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else if (cmp_xly) begin
                  lt      <= 1'b1;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else if (idx_q == '0) begin
                  eq      <= 1'b1;
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q - 1'b1;
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Directed bench for serial_comp_ctrl (WIDTH=8) with a behavioural comparator slice
// that can be forced to return an invalid all-zero code.
module tb_serial_comp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a, b;
   logic       busy, done, lt, gt, eq, err;
   logic [1:0] cmp_x, cmp_y;
   logic       cmp_xly, cmp_xgy, cmp_xey;
   logic       slice_kill;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign cmp_xly = !slice_kill && (cmp_x < cmp_y);
   assign cmp_xgy = !slice_kill && (cmp_x > cmp_y);
   assign cmp_xey = !slice_kill && (cmp_x == cmp_y);

   serial_comp_ctrl #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .lt      (lt),
      .gt      (gt),
      .eq      (eq),
      .err     (err),
      .cmp_x   (cmp_x),
      .cmp_y   (cmp_y),
      .cmp_xly (cmp_xly),
      .cmp_xgy (cmp_xgy),
      .cmp_xey (cmp_xey)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One compare; flags are {lt,gt,eq,err}; exp_lat is cycles from accept to done.
   task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int kill_scan, input bit repulse,
                          input logic [3:0] exp_flags, input int exp_lat);
      int lat;
      int busy_n;
      lat    = 0;
      busy_n = 0;
      a      = av;
      b      = bv;
      start  = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         slice_kill = (c == kill_scan);
         if (repulse && c == 1) begin
            start = 1'b1;
            a     = ~av;
            b     = ~bv;
         end else begin
            start = 1'b0;
         end
         if (c == 1) begin
            check({tag, " cmp_x"}, 32'(cmp_x), 32'(av[7:6]));
            check({tag, " cmp_y"}, 32'(cmp_y), 32'(bv[7:6]));
         end
         if (busy) busy_n++;
         if (done) begin
            lat = c;
            break;
         end
         step();
      end
      slice_kill = 1'b0;
      start      = 1'b0;
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " flags"}, 32'({lt, gt, eq, err}), 32'(exp_flags));
      check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_lat));
      step();
      check({tag, " done after"}, 32'(done), 32'd0);
      check({tag, " busy after"}, 32'(busy), 32'd0);
      check({tag, " flags held"}, 32'({lt, gt, eq, err}), 32'(exp_flags));
      check({tag, " cmp idle"}, 32'({cmp_x, cmp_y}), 32'd0);
   endtask

   logic [7:0] blist [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h40, 8'h55, 8'h7F,
                              8'h80, 8'hAA, 8'hC3, 8'hFF};

   initial begin
      logic [3:0] ef;
      int         m;
      logic [7:0] ai;
      int         saw_done;

      rst        = 1'b1;
      start      = 1'b0;
      a          = '0;
      b          = '0;
      slice_kill = 1'b0;
      step();
      step();
      check("reset outputs", 32'({busy, done, lt, gt, eq, err}), 32'd0);
      check("reset cmp", 32'({cmp_x, cmp_y}), 32'd0);
      rst = 1'b0;
      step();

      run_cmp("t1 gt", 8'hB4, 8'h74, 0, 1'b0, 4'b0100, 2);
      run_cmp("t2 eq", 8'h5A, 8'h5A, 0, 1'b0, 4'b0010, 5);
      run_cmp("t3 lt", 8'h12, 8'h13, 0, 1'b0, 4'b1000, 5);
      run_cmp("t4 err", 8'h5A, 8'h5A, 2, 1'b0, 4'b0001, 3);
      run_cmp("t5 repulse", 8'h12, 8'h13, 0, 1'b1, 4'b1000, 5);

      // Reset during the second scan cycle.
      a     = 8'h5A;
      b     = 8'h5A;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6 outputs", 32'({busy, done, lt, gt, eq, err}), 32'd0);
      check("t6 cmp", 32'({cmp_x, cmp_y}), 32'd0);
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (done || busy) saw_done = 1;
         step();
      end
      check("t6 quiet", 32'(saw_done), 32'd0);
      run_cmp("t6 restart", 8'hB4, 8'h74, 0, 1'b0, 4'b0100, 2);

      // Sweep of every A against a spread of B values.
      for (int ia = 0; ia < 256; ia++) begin
         for (int ib = 0; ib < 12; ib++) begin
            ai = 8'(ia);
            if (ai < blist[ib])      ef = 4'b1000;
            else if (ai > blist[ib]) ef = 4'b0100;
            else                     ef = 4'b0010;
            m = 1;
            for (int d = 3; d > 0; d--) begin
               if (((ai >> (2 * d)) & 8'h3) == ((blist[ib] >> (2 * d)) & 8'h3)) m++;
               else break;
            end
            run_cmp("sweep", ai, blist[ib], 0, 1'b0, ef, m + 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
